// File: rtl/cl_frame_capture.sv
// CameraLink receive-side frame capture: decodes LVAL/FVAL/DVAL and pixel bits,
// checks line/frame geometry and keeps frame and error statistics.
module cl_frame_capture #(
  parameter int LINE_PIXELS = 320,
  parameter int FRAME_LINES = 256
) (
  input  logic        pClk,
  input  logic        rst,
  input  logic [27:0] rx,
  output logic [15:0] pix_dat,
  output logic        pix_valid,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err,
  output logic        dval_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  localparam logic [9:0] LP    = 10'(LINE_PIXELS);
  localparam logic [9:0] FL    = 10'(FRAME_LINES);
  localparam logic [9:0] LP_M1 = 10'(LINE_PIXELS - 1);
  localparam logic [9:0] FL_M1 = 10'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FRAME,
    S_LINE
  } state_t;

  state_t      state;
  logic [27:0] rx_q;
  logic        fval_q;
  logic        lval_q;
  logic        primed;
  logic [9:0]  pix_cnt;
  logic [9:0]  line_cnt;

  logic        lval;
  logic        fval;
  logic        dval;
  logic [15:0] pix;
  logic        unused_bits;

  assign lval = rx_q[24];
  assign fval = rx_q[25];
  assign dval = rx_q[26];
  assign pix  = {rx_q[5], rx_q[27], rx_q[6], rx_q[4:0],
                 2'b00, rx_q[14:12], rx_q[9:7]};
  assign unused_bits = ^{rx_q[23:15], rx_q[11:10]};

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic       fval_rise;
  logic       fval_fall;
  logic       lval_rise;
  logic       lval_fall;
  logic       line_start;
  logic       emit;
  logic       close_line;
  logic       close_frame;
  logic       line_bad;
  logic       frame_bad;
  logic       derr;
  logic [9:0] cur_pix;
  logic [9:0] cur_line;
  logic [9:0] lines_done;
  logic [8:0] err_sum;

  always_comb begin
    fval_rise = fval & ~fval_q;
    fval_fall = ~fval & fval_q;
    lval_rise = lval & ~lval_q;
    lval_fall = ~lval & lval_q;
    // A line may open in the same cycle as the frame or its first pixel
    line_start = lval_rise & fval &
                 ((state == S_FRAME) | ((state == S_ARMED) & fval_rise));
    cur_pix  = line_start ? 10'd0 : pix_cnt;
    cur_line = (state == S_ARMED) ? 10'd0 : line_cnt;
    emit = ((state == S_LINE) | line_start) & fval & lval & dval;
    close_line  = (state == S_LINE) & (lval_fall | fval_fall);
    close_frame = ((state == S_FRAME) | (state == S_LINE)) & fval_fall;
    line_bad    = close_line & (pix_cnt != LP);
    lines_done  = close_line ? sat_inc(line_cnt) : line_cnt;
    frame_bad   = close_frame & (lines_done != FL);
    derr = dval & ~(lval & fval) & (state != S_IDLE);
    err_sum = 9'(err_cnt) + 9'(line_bad) + 9'(frame_bad) + 9'(derr);
  end

  always_ff @(posedge pClk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_q       <= '0;
      fval_q     <= 1'b0;
      lval_q     <= 1'b0;
      primed     <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      pix_dat    <= '0;
      pix_valid  <= 1'b0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      dval_err   <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      rx_q   <= rx;
      fval_q <= fval;
      lval_q <= lval;
      primed <= 1'b1;

      pix_valid  <= emit;
      sof        <= emit & (cur_line == 10'd0) & (cur_pix == 10'd0);
      eol        <= emit & (cur_pix == LP_M1);
      eof        <= emit & (cur_pix == LP_M1) & (cur_line == FL_M1);
      frame_done <= close_frame;
      line_err   <= line_bad;
      frame_err  <= frame_bad;
      dval_err   <= derr;
      if (emit)
        pix_dat <= pix;
      if (close_frame & ~frame_bad)
        frame_cnt <= frame_cnt + 16'd1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];

      unique case (state)
        S_IDLE: begin
          // rx_q is only meaningful once it has sampled rx after reset
          if (primed & ~fval)
            state <= S_ARMED;
        end
        S_ARMED: begin
          if (fval_rise) begin
            line_cnt <= '0;
            pix_cnt  <= {9'd0, emit};
            state    <= line_start ? S_LINE : S_FRAME;
          end
        end
        S_FRAME: begin
          if (fval_fall) begin
            state <= S_ARMED;
          end else if (line_start) begin
            pix_cnt <= {9'd0, emit};
            state   <= S_LINE;
          end
        end
        S_LINE: begin
          if (fval_fall) begin
            line_cnt <= sat_inc(line_cnt);
            state    <= S_ARMED;
          end else if (lval_fall) begin
            line_cnt <= sat_inc(line_cnt);
            state    <= S_FRAME;
          end else if (emit) begin
            pix_cnt <= sat_inc(pix_cnt);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/cl_frame_capture.md
# cl_frame_capture

Receive-side CameraLink frame capture stage, sitting directly downstream of the CameraLink transmitter's 28-bit parallel bus (after the Channel Link deserializer, or in loopback on the board). Decodes LVAL/FVAL/DVAL and the 16-bit pixel bit mapping back into a pixel stream with frame and line markers. Checks frame geometry against the configured line and frame sizes, and keeps frame and error statistics for bring-up and board self-test.

## Interface
- LINE_PIXELS, 320, DVAL-qualified pixels expected per line (1..1023)
- FRAME_LINES, 256, lines expected per frame (1..1023)
- pClk  in  1  pixel clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- rx  in  28  parallel CameraLink bits, synchronous to pClk
- pix_dat  out  16  reconstructed pixel
- pix_valid  out  1  pix_dat valid this cycle
- sof  out  1  with pix_valid: first pixel of the frame
- eol  out  1  with pix_valid: pixel number LINE_PIXELS-1 of a line
- eof  out  1  with pix_valid: pixel LINE_PIXELS-1 of line FRAME_LINES-1
- frame_done  out  1  one-cycle pulse when FVAL falls on a tracked frame
- line_err  out  1  one-cycle pulse: line closed with pixel count != LINE_PIXELS
- frame_err  out  1  one-cycle pulse: frame closed with line count != FRAME_LINES
- dval_err  out  1  one-cycle pulse: DVAL high while LVAL or FVAL low
- frame_cnt  out  16  good frames received; wraps at 0xFFFF->0
- err_cnt  out  8  total error pulses; saturates at 255

## Operation
- Input stage: rx is registered into rx_q every cycle. All decoding uses rx_q.
- Control bits:
  - LVAL = rx_q[24], FVAL = rx_q[25], DVAL = rx_q[26].
  - rx_q[23:15] and rx_q[11:10] are ignored.
- Pixel mapping:
  - pix[12:8] = rx_q[4:0], pix[15] = rx_q[5], pix[13] = rx_q[6], pix[14] = rx_q[27]
  - pix[2:0] = rx_q[9:7], pix[5:3] = rx_q[14:12]
  - pix[7:6] = 0 (bits 7:6 are not carried on the link).
- Previous-cycle copies of FVAL and LVAL give edge detection.
- States:
  - IDLE: wait for FVAL low for at least one cycle, then go to ARMED. A frame already in progress at reset is never captured.
  - ARMED: on FVAL rising edge, clear line_cnt and pix_cnt and go to FRAME.
  - FRAME:
    - LVAL rising edge: clear pix_cnt and go to LINE.
    - FVAL falling edge: close the frame, go to ARMED.
  - LINE:
    - Each cycle with FVAL & LVAL & DVAL emits a pixel and increments pix_cnt.
    - LVAL falling edge: close the line, increment line_cnt, go to FRAME.
    - FVAL falling edge: close the line, then close the frame, go to ARMED.
- Counters: pix_cnt and line_cnt are 10 bits and saturate at 1023.
- Line close: line_err pulses if pix_cnt != LINE_PIXELS.
- Frame close:
  - frame_done pulses.
  - frame_err pulses if line_cnt != FRAME_LINES.
  - frame_cnt increments only when frame_err is not raised for that frame.
- LVAL activity while FVAL is low (for example the transmitter's trailing LVAL pulse after frame end) is ignored. It causes no pixels, no line count and no error.
- dval_err pulses in every cycle where DVAL=1 and (LVAL=0 or FVAL=0), in any state except IDLE. No pixel is emitted in that cycle.
- Markers are count-based, from the pix_cnt and line_cnt values before the increment:
  - sof when line_cnt==0 and pix_cnt==0
  - eol when pix_cnt==LINE_PIXELS-1
  - eof when eol and line_cnt==FRAME_LINES-1.
- err_cnt adds the number of error pulses raised in a cycle (0..3) and saturates at 255.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, rx_q 0.
- Latency: a word on rx at rising edge k appears on pix_dat/pix_valid after edge k+1, i.e. 2 edges, fixed.
- Alignment: sof, eol and eof align with their pix_valid cycle.
- Line close: line_err appears 2 edges after LVAL falls at rx.
- Frame close: frame_done and frame_err appear 2 edges after FVAL falls at rx. frame_cnt updates in the same cycle as frame_done.
- Simultaneous LVAL and FVAL fall: line_err and frame_err may pulse in the same cycle, and err_cnt adds 2. The frame's line_cnt includes the closed line.
- pix_dat holds its last value when pix_valid=0.
- No back-pressure: one pixel per cycle is sustained.
- Reset mid-frame: outputs clear immediately. After release the block returns to IDLE, so the remainder of that frame is discarded with no error pulses.

## Test plan
- Nominal: 3 frames of 256 lines x 320 DVAL pixels, 10-cycle FVAL-to-LVAL gap, trailing LVAL pulse with FVAL low after each frame.
  - 81920 pix_valid per frame; sof once and eof once per frame; 256 eol per frame.
  - frame_done x3, frame_cnt=3, err_cnt=0.
- Bit mapping: drive rx encoding pixel 0xA5C3 → pix_dat=0xA503. Walking-one over all 16 pixel bits → every bit except 7:6 round-trips.
- Short line: line 5 carries 319 pixels → one line_err 2 edges after LVAL falls. The frame still has 256 lines, so frame_cnt increments and err_cnt=1.
- Short frame: FVAL falls after 200 lines → frame_done with frame_err, frame_cnt unchanged, err_cnt=1.
- Reset mid-frame: assert rst at line 100, release, and let the frame continue → no pixels or errors until the next full frame. That frame is captured cleanly with frame_cnt=1.
- Protocol violation: DVAL=1 with LVAL=0 inside a frame for 4 cycles → 4 dval_err pulses, err_cnt=4, no pix_valid. Saturation: 300 errors → err_cnt=255.
